canvas_painter: RTL
===================

// Module: canvas_painter
// PURPOSE
//  Write side of the 28x28 drawing canvas: converts mouse cursor screen coords into a canvas
//  cell and stamps a 3x3 brush into the canvas register array, one cell per clock. Owns the
//  canvas storage that the VGA color mapper reads (bits [10:3] = grey level) and that the NN
//  input stage consumes. Also provides a sequenced clear.
// PARAMETERS
//  ORIGIN_X    199       screen X of canvas cell (0,0) left edge
//  ORIGIN_Y    43        screen Y of canvas cell (0,0) top edge
//  CELL_PX     14        pixels per cell side
//  GRID        28        cells per side
//  CENTER_INC  16'h0400  increment applied to brush centre cell
//  EDGE_INC    16'h0100  increment applied to 4 orthogonal neighbours
//  MAX_VAL     16'h07FF  saturation ceiling (full white on display)
// PORTS
//  Clk         in   1            system clock
//  Reset       in   1            synchronous, active-high reset
//  frame_tick  in   1            1-cycle pulse per VGA frame; paces stamping
//  MouseX      in   10           cursor screen X
//  MouseY      in   10           cursor screen Y
//  paint       in   1            left button level
//  clear       in   1            clear request level
//  canvas      out  [15:0] x[GRID][GRID]  canvas[x][y], registered
//  busy        out  1            high while state != IDLE
//  stamp_done  out  1            1-cycle pulse after a stamp completes
// BEHAVIOUR
//  Reset: all canvas cells 0, state IDLE, busy 0, stamp_done 0, counters 0.
//  Mapping: X=MouseX-ORIGIN_X, Y=MouseY-ORIGIN_Y (unsigned, 10b); on_canvas iff
//   MouseX>=ORIGIN_X && MouseY>=ORIGIN_Y && X<GRID*CELL_PX && Y<GRID*CELL_PX;
//   cx=X/CELL_PX, cy=Y/CELL_PX (constant-divide or compare chain, 5b each).
//  States: IDLE, STAMP, CLEAR.
//  IDLE: clear=1 -> CLEAR (priority). Else frame_tick && paint && on_canvas -> latch cx,cy,
//   k=0, -> STAMP. Otherwise hold.
//  STAMP: k counts 0..8; offset dx=k%3-1, dy=k/3-1; target (cx+dx,cy+dy).
//   k=4 centre: +CENTER_INC; k in {1,3,5,7}: +EDGE_INC; diagonals: no write.
//   Target outside 0..GRID-1 on either axis: no write, cycle still consumed.
//   Write: canvas <= min(old+inc, MAX_VAL), sum computed at 17b, registered same edge.
//   After k=8 -> IDLE, stamp_done=1 for next cycle. Fixed 9 cycles per stamp.
//   frame_tick and paint ignored in STAMP. clear=1 in STAMP -> CLEAR immediately
//   (writes already made are kept until cleared; no stamp_done).
//  CLEAR: column counter c 0..GRID-1; each cycle zero canvas[c][0..GRID-1]; GRID cycles,
//   then IDLE. clear ignored while in CLEAR; if still high in IDLE, clear restarts.
//  Latency: frame_tick sampled at edge T -> busy high T+1..T+9, stamp_done high T+10.
//  At most one stamp per frame_tick; held cursor accumulates brightness each frame.
//  Reset mid-STAMP/CLEAR: next cycle fully reset state (canvas zero, IDLE).
// TESTING
//  1 Reset for 2 cycles -> all 784 cells 0, busy 0, stamp_done 0.
//  2 MouseX=272,MouseY=183,paint=1, one frame_tick -> canvas[5][10]=0x0400; [4][10],[6][10],
//    [5][9],[5][11]=0x0100; diagonals 0; busy 9 cycles; stamp_done 10 cycles after tick.
//  3 MouseX=199,MouseY=43, paint, 3 ticks -> [0][0]=0x07FF (saturated on 2nd), [1][0],[0][1]
//    =0x0300, [1][1]=0, no other cell changed, each stamp still 9 cycles.
//  4 MouseX=198 (or 591), paint, tick -> no cell changes, busy stays 0, no stamp_done.
//  5 After test 2, tick then clear=1 on 4th STAMP cycle -> CLEAR, busy 28 cycles, all cells 0,
//    no stamp_done; clear held -> second 28-cycle clear.
//  6 frame_tick during STAMP, and tick with paint=0 -> no extra stamp, canvas unchanged.

Source files
------------

// File: rtl/canvas_painter.sv
// canvas_painter: maps the cursor to a 28x28 canvas cell, stamps a saturating 3x3 brush one cell per clock, and clears the canvas column by column.
module canvas_painter #(
  parameter int          ORIGIN_X   = 199,
  parameter int          ORIGIN_Y   = 43,
  parameter int          CELL_PX    = 14,
  parameter int          GRID       = 28,
  parameter logic [15:0] CENTER_INC = 16'h0400,
  parameter logic [15:0] EDGE_INC   = 16'h0100,
  parameter logic [15:0] MAX_VAL    = 16'h07FF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [9:0]  MouseX,
  input  logic [9:0]  MouseY,
  input  logic        paint,
  input  logic        clear,
  output logic [15:0] canvas [GRID][GRID],
  output logic        busy,
  output logic        stamp_done
);
  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cx_q, cx_d, cy_q, cy_d, c_q, c_d;
  logic [3:0]  k_q, k_d;
  logic        done_q, done_d;
  logic [15:0] canvas_q [GRID][GRID];
  logic [9:0]  rel_x, rel_y, div_x, div_y;
  logic        on_canvas;
  logic [1:0]  dx, dy;
  logic [5:0]  tx, ty;
  logic        in_grid, wr;
  logic [15:0] inc, old, sat;
  logic [16:0] sum;
  assign rel_x = MouseX - 10'(ORIGIN_X);
  assign rel_y = MouseY - 10'(ORIGIN_Y);
  assign on_canvas = MouseX >= 10'(ORIGIN_X) && MouseY >= 10'(ORIGIN_Y) &&
                     rel_x < 10'(GRID * CELL_PX) && rel_y < 10'(GRID * CELL_PX);
  assign div_x = rel_x / 10'(CELL_PX);
  assign div_y = rel_y / 10'(CELL_PX);
  // k walks the 3x3 brush row by row; off-grid targets of the -1 offset wrap to 63 and fail the bound
  assign dx = (k_q == 4'd0 || k_q == 4'd3 || k_q == 4'd6) ? 2'd0 :
              (k_q == 4'd1 || k_q == 4'd4 || k_q == 4'd7) ? 2'd1 : 2'd2;
  assign dy = k_q < 4'd3 ? 2'd0 : k_q < 4'd6 ? 2'd1 : 2'd2;
  assign tx = {1'b0, cx_q} + {4'b0, dx} - 6'd1;
  assign ty = {1'b0, cy_q} + {4'b0, dy} - 6'd1;
  assign in_grid = tx < 6'(GRID) && ty < 6'(GRID);
  assign inc = k_q == 4'd4 ? CENTER_INC : k_q[0] ? EDGE_INC : 16'h0000;
  assign old = canvas_q[tx[4:0]][ty[4:0]];
  assign sum = {1'b0, old} + {1'b0, inc};
  assign sat = sum > {1'b0, MAX_VAL} ? MAX_VAL : sum[15:0];
  assign wr = state_q == STAMP && !clear && inc != 16'h0000 && in_grid;
  assign busy = state_q != IDLE;
  assign stamp_done = done_q;
  assign canvas = canvas_q;
  always_comb begin
    state_d = state_q;
    cx_d = cx_q;
    cy_d = cy_q;
    k_d = k_q;
    c_d = c_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          c_d = '0;
        end else if (frame_tick && paint && on_canvas) begin
          state_d = STAMP;
          cx_d = div_x[4:0];
          cy_d = div_y[4:0];
          k_d = '0;
        end
      end
      STAMP: begin
        if (clear) begin
          state_d = CLEAR;
          c_d = '0;
        end else if (k_q == 4'd8) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else k_d = k_q + 4'd1;
      end
      CLEAR: begin
        state_d = c_q == 5'(GRID - 1) ? IDLE : CLEAR;
        c_d = c_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cx_q <= '0;
      cy_q <= '0;
      k_q <= '0;
      c_q <= '0;
      done_q <= 1'b0;
      for (int x = 0; x < GRID; x++)
        for (int y = 0; y < GRID; y++) canvas_q[x][y] <= '0;
    end else begin
      state_q <= state_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      k_q <= k_d;
      c_q <= c_d;
      done_q <= done_d;
      if (wr) canvas_q[tx[4:0]][ty[4:0]] <= sat;
      if (state_q == CLEAR)
        for (int y = 0; y < GRID; y++) canvas_q[c_q][y] <= '0;
    end
  end
endmodule
